pixel_cmd_fifo: RTL and testbench

- Parametrised single-clock FIFO that buffers pixel write commands (hpos, vpos, colour) between the drawing engine and the framebuffer write port.
- Successor to the three-parallel-FIFO pixel buffer. Uses one packed storage array with one pointer pair, so all fields stay aligned by construction.
- Adds:
  - exact fill count
  - almost-full threshold
  - selectable first-word-fall-through (FWFT) or registered read
  - synchronous flush
  - sticky overflow/underflow error flags

---
 rtl/pixel_cmd_fifo_if.sv | 58 +++++
 rtl/pixel_cmd_fifo.sv | 196 +++++++++++++++++++
 tb/tb_pixel_cmd_fifo.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_cmd_fifo_if.sv
// -----------------------------------------------------------------------------
// pixel_cmd_fifo_if
//
// Bundles the pixel command FIFO's write side, read side, status and error
// signals so the drawing engine and the framebuffer write port share one port.
//
// Modports:
//   master : the client. Drives flush/push/pop/clear_err and the write fields.
//            Observes the read fields and the status and error flags.
//   slave  : the FIFO itself. This is the mirror of the master modport.
//
// Signals:
//   flush        synchronous empty request
//   push / pop   write / read requests
//   hpos_write, vpos_write, RGB_write   command being written
//   hpos_read,  vpos_read,  RGB_read    command at the read port
//   rd_valid     read fields hold valid data
//   empty, full, almost_full, count     fill status
//   clear_err    clears the sticky error flags
//   overflow     sticky flag, set when a push was rejected
//   underflow    sticky flag, set when a pop was rejected
// -----------------------------------------------------------------------------
interface pixel_cmd_fifo_if #(
  parameter int HPOS_WIDTH = 11,
  parameter int VPOS_WIDTH = 10,
  parameter int RGB_WIDTH  = 3,
  parameter int CNT_WIDTH  = 5
);
  logic                  flush;
  logic                  push;
  logic                  pop;
  logic                  clear_err;
  logic [HPOS_WIDTH-1:0] hpos_write;
  logic [VPOS_WIDTH-1:0] vpos_write;
  logic [RGB_WIDTH-1:0]  RGB_write;
  logic [HPOS_WIDTH-1:0] hpos_read;
  logic [VPOS_WIDTH-1:0] vpos_read;
  logic [RGB_WIDTH-1:0]  RGB_read;
  logic                  rd_valid;
  logic                  empty;
  logic                  full;
  logic                  almost_full;
  logic [CNT_WIDTH-1:0]  count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, push, pop, clear_err, hpos_write, vpos_write, RGB_write,
    input  hpos_read, vpos_read, RGB_read, rd_valid, empty, full,
           almost_full, count, overflow, underflow
  );

  modport slave (
    input  flush, push, pop, clear_err, hpos_write, vpos_write, RGB_write,
    output hpos_read, vpos_read, RGB_read, rd_valid, empty, full,
           almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/pixel_cmd_fifo.sv
// -----------------------------------------------------------------------------
// pixel_cmd_fifo
//
// Single-clock FIFO for pixel write commands {hpos, vpos, rgb}. The FIFO keeps
// all three fields in one packed storage array and uses one read pointer and
// one write pointer, so the fields cannot drift out of alignment.
//
// Features:
//   - exact fill count
//   - almost_full threshold
//   - FWFT or registered-read output
//   - synchronous flush
//   - sticky overflow and underflow flags
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  pixel_cmd_fifo_if.slave (requests, write/read data, status, errors)
//
// Parameters:
//   HPOS_WIDTH, VPOS_WIDTH, RGB_WIDTH   widths of the command fields
//   DEPTH        number of entries (>= 2, any integer)
//   AFULL_LEVEL  almost_full is asserted when count >= AFULL_LEVEL (1..DEPTH)
//   FWFT         1 = head entry shown on the read fields without a pop
//                0 = the read fields are registered and loaded on each pop
//   CNT_WIDTH    width of count
// -----------------------------------------------------------------------------
module pixel_cmd_fifo #(
  parameter int HPOS_WIDTH  = 11,
  parameter int VPOS_WIDTH  = 10,
  parameter int RGB_WIDTH   = 3,
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = DEPTH - 2,
  parameter int FWFT        = 1,
  parameter int CNT_WIDTH   = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  pixel_cmd_fifo_if.slave      bus
);

  localparam int DATA_W = HPOS_WIDTH + VPOS_WIDTH + RGB_WIDTH;
  localparam int PTR_W  = $clog2(DEPTH);

  // Storage is deliberately not reset, so it can map onto plain registers or
  // onto RAM.
  logic [DATA_W-1:0]    mem [DEPTH];

  logic [PTR_W-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [CNT_WIDTH-1:0] count_reg, count_next;
  logic                 overflow_reg, overflow_next;
  logic                 underflow_reg, underflow_next;

  logic                 empty_w;
  logic                 full_w;
  logic                 push_ok;
  logic                 pop_ok;
  logic                 ovf_event;
  logic                 udf_event;
  logic [DATA_W-1:0]    wr_data_w;
  logic [DATA_W-1:0]    rd_data_w;
  logic                 rd_valid_w;

  // Pointers wrap at DEPTH-1. DEPTH does not have to be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Status decode
  // The flags are decoded from the count register only. They never depend on
  // the inputs of the current cycle.
  // ---------------------------------------------------------------------------
  assign empty_w = (count_reg == '0);
  assign full_w  = (count_reg == CNT_WIDTH'(DEPTH));

  assign bus.empty       = empty_w;
  assign bus.full        = full_w;
  assign bus.almost_full = (count_reg >= CNT_WIDTH'(AFULL_LEVEL));
  assign bus.count       = count_reg;
  assign bus.overflow    = overflow_reg;
  assign bus.underflow   = underflow_reg;

  // ---------------------------------------------------------------------------
  // Accept logic
  // flush overrides both requests. In a flush cycle nothing is accepted and
  // no error is flagged. A push into a full FIFO is accepted only when a pop
  // frees a slot in the same cycle.
  // ---------------------------------------------------------------------------
  assign pop_ok    = !bus.flush && bus.pop && !empty_w;
  assign push_ok   = !bus.flush && bus.push && (!full_w || pop_ok);
  assign ovf_event = !bus.flush && bus.push && !push_ok;
  assign udf_event = !bus.flush && bus.pop && !pop_ok;

  assign wr_data_w = {bus.hpos_write, bus.vpos_write, bus.RGB_write};

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;

    if (bus.flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push_ok) begin
        wr_ptr_next = ptr_inc(wr_ptr_reg);
      end
      if (pop_ok) begin
        rd_ptr_next = ptr_inc(rd_ptr_reg);
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  // An error event in the same cycle as clear_err still sets the flag.
  always_comb begin
    overflow_next  = (overflow_reg  && !bus.clear_err) || ovf_event;
    underflow_next = (underflow_reg && !bus.clear_err) || udf_event;
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage write
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= wr_data_w;
    end
  end

  // ---------------------------------------------------------------------------
  // Read port
  // ---------------------------------------------------------------------------
  generate
    if (FWFT != 0) begin : g_fwft
      // The head entry is shown directly from storage. While the FIFO is
      // empty the fields are forced to zero, so stale storage never appears
      // on the read port. This also keeps the post-reset value at zero.
      assign rd_valid_w = !empty_w;
      assign rd_data_w  = rd_valid_w ? mem[rd_ptr_reg] : '0;
    end else begin : g_registered
      logic [DATA_W-1:0] rd_data_reg;
      logic              rd_valid_reg;

      // The data register loads only on an accepted pop and otherwise holds
      // its value. This includes flush cycles. rd_valid marks the single
      // cycle after each pop.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_data_reg  <= '0;
          rd_valid_reg <= 1'b0;
        end else begin
          rd_valid_reg <= pop_ok;
          if (pop_ok) begin
            rd_data_reg <= mem[rd_ptr_reg];
          end
        end
      end

      assign rd_valid_w = rd_valid_reg;
      assign rd_data_w  = rd_data_reg;
    end
  endgenerate

  assign bus.rd_valid = rd_valid_w;
  assign {bus.hpos_read, bus.vpos_read, bus.RGB_read} = rd_data_w;

endmodule

// File: tb/tb_pixel_cmd_fifo.sv
// -----------------------------------------------------------------------------
// tb_pixel_cmd_fifo
//
// Two instances run side by side on the same stimulus:
//   dut0 : DEPTH=4, AFULL_LEVEL=3, FWFT=1
//   dut1 : DEPTH=5, AFULL_LEVEL=4, FWFT=0
// Each instance is compared on every falling edge against an ordered-list
// model of the FIFO. Directed phases pin the model to hand-computed values,
// and then a long randomized phase follows.
// -----------------------------------------------------------------------------
module tb_pixel_cmd_fifo;

  localparam int D0  = 4;
  localparam int A0  = 3;
  localparam int D1  = 5;
  localparam int A1  = 4;
  localparam int CW0 = $clog2(D0 + 1);
  localparam int CW1 = $clog2(D1 + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        flush = 1'b0, push = 1'b0, pop = 1'b0, clear_err = 1'b0;
  logic [10:0] hw = '0;
  logic [9:0]  vw = '0;
  logic [2:0]  cw = '0;

  pixel_cmd_fifo_if #(.HPOS_WIDTH(11), .VPOS_WIDTH(10), .RGB_WIDTH(3), .CNT_WIDTH(CW0)) bus0 ();
  pixel_cmd_fifo_if #(.HPOS_WIDTH(11), .VPOS_WIDTH(10), .RGB_WIDTH(3), .CNT_WIDTH(CW1)) bus1 ();

  assign bus0.flush = flush;  assign bus1.flush = flush;
  assign bus0.push = push;    assign bus1.push = push;
  assign bus0.pop = pop;      assign bus1.pop = pop;
  assign bus0.clear_err = clear_err;  assign bus1.clear_err = clear_err;
  assign bus0.hpos_write = hw;  assign bus1.hpos_write = hw;
  assign bus0.vpos_write = vw;  assign bus1.vpos_write = vw;
  assign bus0.RGB_write = cw;   assign bus1.RGB_write = cw;

  pixel_cmd_fifo #(.HPOS_WIDTH(11), .VPOS_WIDTH(10), .RGB_WIDTH(3), .DEPTH(D0),
                   .AFULL_LEVEL(A0), .FWFT(1), .CNT_WIDTH(CW0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));

  pixel_cmd_fifo #(.HPOS_WIDTH(11), .VPOS_WIDTH(10), .RGB_WIDTH(3), .DEPTH(D1),
                   .AFULL_LEVEL(A1), .FWFT(0), .CNT_WIDTH(CW1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_vec = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  // Model: the contents of each FIFO as an ordered list, oldest entry first.
  int          m_cnt [2];
  logic [23:0] m_list [2][8];
  logic        m_ovf [2];
  logic        m_udf [2];
  logic        m_rdv1;
  logic [23:0] m_out1;

  function automatic int dep(input int c);
    return (c == 0) ? D0 : D1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_cnt[c] = 0;
      m_ovf[c] = 1'b0;
      m_udf[c] = 1'b0;
    end
    m_rdv1 = 1'b0;
    m_out1 = '0;
  endtask

  // Applies one clock edge to the model, using the inputs as they stood
  // before the edge.
  task automatic model_step();
    for (int c = 0; c < 2; c++) begin
      logic        po_ok, pu_ok;
      logic [23:0] head;
      if (clear_err) begin
        m_ovf[c] = 1'b0;
        m_udf[c] = 1'b0;
      end
      if (flush) begin
        m_cnt[c] = 0;
        if (c == 1) m_rdv1 = 1'b0;
      end else begin
        po_ok = pop && (m_cnt[c] > 0);
        pu_ok = push && ((m_cnt[c] < dep(c)) || po_ok);
        head  = m_list[c][0];
        if (po_ok) begin
          for (int i = 0; i < 7; i++) m_list[c][i] = m_list[c][i+1];
          m_cnt[c]--;
        end
        if (pu_ok) begin
          m_list[c][m_cnt[c]] = {hw, vw, cw};
          m_cnt[c]++;
        end
        if (push && !pu_ok) m_ovf[c] = 1'b1;
        if (pop && !po_ok)  m_udf[c] = 1'b1;
        if (c == 1) begin
          m_rdv1 = po_ok;
          if (po_ok) m_out1 = head;
        end
      end
    end
  endtask

  task automatic check_cfg(input int c, input logic [31:0] cnt, input logic e, input logic f,
                           input logic af, input logic ov, input logic ud, input logic rv,
                           input logic [23:0] data);
    chk($sformatf("c%0d count", c), cnt, m_cnt[c]);
    chk($sformatf("c%0d empty", c), e, m_cnt[c] == 0);
    chk($sformatf("c%0d full", c), f, m_cnt[c] == dep(c));
    chk($sformatf("c%0d almost_full", c), af, m_cnt[c] >= ((c == 0) ? A0 : A1));
    chk($sformatf("c%0d overflow", c), ov, m_ovf[c]);
    chk($sformatf("c%0d underflow", c), ud, m_udf[c]);
    if (c == 0) begin
      chk("c0 rd_valid", rv, m_cnt[0] != 0);
      if (m_cnt[0] != 0) chk("c0 read data", data, m_list[0][0]);
    end else begin
      chk("c1 rd_valid", rv, m_rdv1);
      chk("c1 read data", data, m_out1);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check_cfg(0, 32'(bus0.count), bus0.empty, bus0.full, bus0.almost_full, bus0.overflow,
                bus0.underflow, bus0.rd_valid, {bus0.hpos_read, bus0.vpos_read, bus0.RGB_read});
      check_cfg(1, 32'(bus1.count), bus1.empty, bus1.full, bus1.almost_full, bus1.overflow,
                bus1.underflow, bus1.rd_valid, {bus1.hpos_read, bus1.vpos_read, bus1.RGB_read});
    end
  end

  // One clock cycle. The task is entered at posedge+1. It drives the inputs,
  // updates the model on the edge, and returns at posedge+1.
  task automatic cyc(input logic f, input logic pu, input logic po, input logic ce,
                     input logic [10:0] h, input logic [9:0] v, input logic [2:0] col);
    flush = f; push = pu; pop = po; clear_err = ce;
    hw = h; vw = v; cw = col;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_push(input int h);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 11'(h), 10'(h * 3 + 1), 3'(h));
  endtask
  task automatic do_pop();
    cyc(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, '0);
  endtask
  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask
  task automatic settle();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, '0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, " d0 count"}, 32'(bus0.count), 0);
    chk({tag, " d0 empty"}, bus0.empty, 1);
    chk({tag, " d0 full"}, bus0.full, 0);
    chk({tag, " d0 almost_full"}, bus0.almost_full, 0);
    chk({tag, " d0 flags"}, {bus0.overflow, bus0.underflow, bus0.rd_valid}, 0);
    chk({tag, " d0 data"}, {bus0.hpos_read, bus0.vpos_read, bus0.RGB_read}, 0);
    chk({tag, " d1 count"}, 32'(bus1.count), 0);
    chk({tag, " d1 empty"}, bus1.empty, 1);
    chk({tag, " d1 flags"}, {bus1.overflow, bus1.underflow, bus1.rd_valid}, 0);
    chk({tag, " d1 data"}, {bus1.hpos_read, bus1.vpos_read, bus1.RGB_read}, 0);
  endtask

  initial begin
    int pu_pct, po_pct;
    logic f, pu, po, ce;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    $display("phase reset");
    chk_reset_values("reset");
    chk_en = 1'b1;

    $display("phase single push/pop");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 11'd5, 10'd7, 3'b101);
    chk("d0 empty after push", bus0.empty, 0);
    chk("d0 count after push", 32'(bus0.count), 1);
    chk("d0 rd_valid after push", bus0.rd_valid, 1);
    chk("d0 fields after push", {bus0.hpos_read, bus0.vpos_read, bus0.RGB_read}, {11'd5, 10'd7, 3'b101});
    chk("d1 rd_valid before pop", bus1.rd_valid, 0);
    do_pop();
    chk("d0 empty after pop", bus0.empty, 1);
    chk("d0 count after pop", 32'(bus0.count), 0);
    chk("d1 rd_valid after pop", bus1.rd_valid, 1);
    chk("d1 fields after pop", {bus1.hpos_read, bus1.vpos_read, bus1.RGB_read}, {11'd5, 10'd7, 3'b101});

    $display("phase fill and overflow");
    settle();
    for (int k = 1; k <= 4; k++) begin
      do_push(k);
      if (k == 2) chk("d0 almost_full at 2", bus0.almost_full, 0);
      if (k == 3) chk("d0 almost_full at 3", bus0.almost_full, 1);
    end
    chk("d0 full at 4", bus0.full, 1);
    do_push(9);
    chk("d0 overflow", bus0.overflow, 1);
    chk("d0 count after overflow", 32'(bus0.count), 4);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("d0 order h%0d", k), 32'(bus0.hpos_read), k);
      do_pop();
    end
    chk("d0 empty after drain", bus0.empty, 1);

    $display("phase full push+pop and wrap");
    settle();
    for (int k = 1; k <= 4; k++) do_push(k);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 11'd10, 10'd31, 3'd2);
    chk("d0 count full push+pop", 32'(bus0.count), 4);
    chk("d0 head after push+pop", 32'(bus0.hpos_read), 2);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("d0 drain %0d", k), 32'(bus0.hpos_read), (k == 3) ? 10 : k + 2);
      do_pop();
    end
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) do_push(20 + r * 4 + i);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("d0 wrap r%0d i%0d", r, i), 32'(bus0.hpos_read), 20 + r * 4 + i);
        do_pop();
      end
    end

    $display("phase underflow and clear_err");
    settle();
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 11'd6, 10'd19, 3'd6);
    chk("d0 count empty push+pop", 32'(bus0.count), 1);
    chk("d0 underflow", bus0.underflow, 1);
    chk("d0 head h6", 32'(bus0.hpos_read), 6);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, '0);
    chk("d0 underflow cleared", bus0.underflow, 0);
    for (int k = 0; k < 3; k++) do_push(40 + k);
    do_push(50);
    chk("d0 overflow set", bus0.overflow, 1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 11'd51, 10'd1, 3'd1);
    chk("d0 overflow event beats clear", bus0.overflow, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, '0);
    chk("d0 overflow cleared", bus0.overflow, 0);

    $display("phase registered read depth 5");
    settle();
    for (int k = 1; k <= 5; k++) do_push(k);
    for (int k = 1; k <= 5; k++) begin
      do_pop();
      chk($sformatf("d1 rd_valid pop %0d", k), bus1.rd_valid, 1);
      chk($sformatf("d1 h pop %0d", k), 32'(bus1.hpos_read), k);
    end
    idle();
    chk("d1 rd_valid idle", bus1.rd_valid, 0);
    chk("d1 hold h5", 32'(bus1.hpos_read), 5);
    chk("d1 empty", bus1.empty, 1);

    $display("phase flush");
    settle();
    for (int k = 1; k <= 3; k++) do_push(k);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 11'd7, 10'd7, 3'd7);
    chk("d0 count after flush", 32'(bus0.count), 0);
    chk("d0 empty after flush", bus0.empty, 1);
    chk("d1 count after flush", 32'(bus1.count), 0);
    idle();
    chk("d0 push in flush not stored", 32'(bus0.count), 0);
    chk("d1 output held over flush", 32'(bus1.hpos_read), 5);

    $display("phase random");
    pu_pct = 50; po_pct = 50;
    for (int n = 0; n < 4000; n++) begin
      if (n % 200 == 0) begin
        pu_pct = $urandom_range(10, 90);
        po_pct = $urandom_range(10, 90);
      end
      f  = ($urandom_range(0, 63) == 0);
      pu = ($urandom_range(0, 99) < pu_pct);
      po = ($urandom_range(0, 99) < po_pct);
      ce = !f && ($urandom_range(0, 31) == 0);
      cyc(f, pu, po, ce, 11'($urandom), 10'($urandom), 3'($urandom));
    end

    $display("phase async reset");
    for (int k = 0; k < 6; k++) do_push(60 + k);
    do_pop();
    idle();
    rst = 1'b1;
    #2;
    chk_reset_values("async reset");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset_values("after reset");
    repeat (3) idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
